// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Fetch stage: PC, single-outstanding imem handshake, redirect/flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        advance,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;
    logic   redirect_pending;

    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            instr            <= NOP_INSTR;
            instr_valid      <= 1'b0;
            mem_req          <= 1'b0;
            misaligned       <= 1'b0;
            redirect_pending <= 1'b0;
        end else if (pc_load) begin
            // Redirect overrides every other event this cycle, including advance.
            pc         <= pc_target;
            misaligned <= 1'b0;
            case (state)
                REQ: begin
                    mem_req <= 1'b0;
                    if (mem_ready) begin
                        // Request already accepted: its response must still be drained.
                        redirect_pending <= 1'b1;
                        state            <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        redirect_pending <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        redirect_pending <= 1'b1;
                    end
                end
                default: begin
                    instr       <= NOP_INSTR;
                    instr_valid <= 1'b0;
                    mem_req     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en && !misaligned) begin
                        if (pc[1:0] == 2'b00) begin
                            mem_req <= 1'b1;
                            state   <= REQ;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (redirect_pending) begin
                            redirect_pending <= 1'b0;
                            state            <= IDLE;
                        end else begin
                            instr       <= mem_rdata;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc          <= pc_plus4;
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        fetch_en, advance, pc_load;
    logic [31:0] pc_target;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        mem_req, instr_valid, misaligned;
    logic [31:0] mem_addr, instr, pc, pc_plus4;
    logic        mem_req2, instr_valid2, misaligned2;
    logic [31:0] mem_addr2, instr2, pc2, pc_plus4_2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .advance(advance),
        .pc_load(pc_load), .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned(misaligned)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .fetch_en(fetch_en), .advance(advance),
        .pc_load(pc_load), .pc_target(pc_target), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr(instr2), .instr_valid(instr_valid2), .pc(pc2), .pc_plus4(pc_plus4_2),
        .misaligned(misaligned2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete fetch from IDLE on dut, with ready_delay cycles of mem_ready low.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int ready_delay);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("req_asserted", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, addr);
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            chk("req_held", {31'd0, mem_req}, 32'd1);
            chk("addr_held", mem_addr, addr);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("req_dropped", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        chk("valid_set", {31'd0, instr_valid}, 32'd1);
        chk("instr_data", instr, data);
        chk("instr_pc", pc, addr);
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        fetch_en = 1'b0; advance = 1'b0; pc_load = 1'b0; pc_target = 32'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_pc4", pc_plus4, 32'h4);
        reset = 1'b0;

        // Minimum-latency first fetch, then sequential fetches with a stalled one
        fetch_one(32'h0, 32'h0050_0093, 0);
        advance = 1'b1; tick(); advance = 1'b0;
        chk("adv_pc", pc, 32'h4);
        chk("adv_valid", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h4, 32'h1111_0001, 0);
        advance = 1'b1; tick(); advance = 1'b0;
        fetch_one(32'h8, 32'h2222_0002, 4);
        advance = 1'b1; tick(); advance = 1'b0;
        fetch_one(32'hC, 32'h3333_0003, 0);
        tick();
        chk("hold_instr", instr, 32'h3333_0003);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);

        // Redirect while the response is in flight
        advance = 1'b1; tick(); advance = 1'b0;
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        pc_load = 1'b1; pc_target = 32'h100; tick(); pc_load = 1'b0;
        chk("wait_redir_pc", pc, 32'h100);
        chk("wait_redir_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_rvalid = 1'b0;
        chk("discard_valid", {31'd0, instr_valid}, 32'd0);
        chk("discard_instr", instr, 32'h3333_0003);
        chk("discard_noreq", {31'd0, mem_req}, 32'd0);
        fetch_one(32'h100, 32'h0000_0100, 0);

        // Redirect and advance together in HOLD
        pc_load = 1'b1; pc_target = 32'h40; tick(); pc_load = 1'b0;
        chk("hold_redir_nop", instr, 32'h0000_0013);
        chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h40, 32'h0000_0040, 1);
        pc_load = 1'b1; pc_target = 32'h80; advance = 1'b1; tick();
        pc_load = 1'b0; advance = 1'b0;
        chk("load_wins_pc", pc, 32'h80);
        chk("load_wins_valid", {31'd0, instr_valid}, 32'd0);

        // Misaligned target blocks fetch until the next redirect
        pc_load = 1'b1; pc_target = 32'h102; tick(); pc_load = 1'b0;
        fetch_en = 1'b1; tick();
        chk("mis_set", {31'd0, misaligned}, 32'd1);
        chk("mis_noreq", {31'd0, mem_req}, 32'd0);
        tick(); fetch_en = 1'b0;
        chk("mis_sticky", {31'd0, misaligned}, 32'd1);
        chk("mis_noreq2", {31'd0, mem_req}, 32'd0);
        pc_load = 1'b1; pc_target = 32'h200; tick(); pc_load = 1'b0;
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        fetch_one(32'h200, 32'h0000_0200, 0);

        // Redirect in REQ before acceptance withdraws the request
        advance = 1'b1; tick(); advance = 1'b0;
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        chk("req_pre_redir", {31'd0, mem_req}, 32'd1);
        pc_load = 1'b1; pc_target = 32'h300; tick(); pc_load = 1'b0;
        chk("req_withdrawn", {31'd0, mem_req}, 32'd0);
        chk("req_redir_pc", pc, 32'h300);
        fetch_one(32'h300, 32'h0000_0300, 0);

        // PC wrap and reset in WAIT on the high-RESET_PC instance
        reset = 1'b1;
        reset2 = 1'b0;
        chk("w_rst_pc", pc2, 32'hFFFF_FFFC);
        chk("w_rst_pc4", pc_plus4_2, 32'h0);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        chk("w_req", {31'd0, mem_req2}, 32'd1);
        chk("w_addr", mem_addr2, 32'hFFFF_FFFC);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; tick(); mem_rvalid = 1'b0;
        chk("w_instr", instr2, 32'h1234_5678);
        advance = 1'b1; tick(); advance = 1'b0;
        chk("w_wrap_pc", pc2, 32'h0);
        chk("w_wrap_pc4", pc_plus4_2, 32'h4);
        chk("w_wrap_mis", {31'd0, misaligned2}, 32'd0);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        reset2 = 1'b1; tick(); reset2 = 1'b0;
        chk("w_rst_instr", instr2, 32'h0000_0013);
        chk("w_rst_pc_again", pc2, 32'hFFFF_FFFC);
        chk("w_rst_req", {31'd0, mem_req2}, 32'd0);
        chk("w_rst_valid", {31'd0, instr_valid2}, 32'd0);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        chk("w_idle_refetch", {31'd0, mem_req2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
